// File: rtl/chroni_pkg.sv
// Shared definitions for the chroni text-mode line writer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package chroni_pkg;

    // Renderer state machine: one character costs 1+1+1+1+8 = 12 cycles.
    typedef enum logic [2:0] {
        IDLE,
        TEXT_RD,
        TEXT_WAIT,
        FONT_RD,
        FONT_WAIT,
        PIXELS
    } state_t;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 8;
    localparam int K_W     = $clog2(GLYPH_W);

    localparam logic [7:0] PIX_FG = 8'h01;
    localparam logic [7:0] PIX_BG = 8'h00;

endpackage

// File: rtl/chroni_glyph_shifter.sv
// Holds one glyph row and shifts it out MSB-first, one pixel per shift.
// Latency: pix/k reflect the loaded glyph the cycle after load.
// Backpressure: none; the caller decides when to shift.
//
// Ports: load/glyph capture a new row and clear k; shift advances one pixel;
//        pix is the current leftmost pixel, k its index, last marks k == 7.
module chroni_glyph_shifter
    import chroni_pkg::*;
(
    input  logic               sys_clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               shift,
    input  logic [GLYPH_W-1:0] glyph,
    output logic               pix,
    output logic [K_W-1:0]     k,
    output logic               last
);

    logic [GLYPH_W-1:0] sr;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            sr <= '0;
            k  <= '0;
        end else if (load) begin
            sr <= glyph;
            k  <= '0;
        end else if (shift) begin
            sr <= {sr[GLYPH_W-2:0], 1'b0};
            k  <= k + K_W'(1);
        end
    end

    assign pix  = sr[GLYPH_W-1];
    assign last = (k == K_W'(GLYPH_W - 1));

endmodule

// File: rtl/chroni_line_writer.sv
// Text-mode scanline renderer filling the back half of a 2-line pixel buffer.
// Latency: trigger at cycle N -> TEXT_RD at N+1, first buf_we at N+5; 12*COLUMNS cycles per line.
// Backpressure: none; a render trigger arriving while busy is dropped and flagged in overrun.
//
// Ports: frame_start/render_start/scanline_start/mode_changed pace and abort rendering;
//        text_addr/text_data and font_addr/font_data are 1-cycle-latency RAM reads;
//        buf_addr/buf_data/buf_we write pixels; busy and sticky overrun report status.
module chroni_line_writer
    import chroni_pkg::*;
#(
    parameter int COLUMNS     = 80,
    parameter int ROWS        = 30,
    parameter int HALF_OFFSET = 640
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        render_start,
    input  logic        scanline_start,
    input  logic        mode_changed,
    input  logic        pixel_scale,
    input  logic [15:0] text_base,
    output logic [15:0] text_addr,
    input  logic [7:0]  text_data,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic        read_text,
    output logic        read_font,
    output logic [10:0] buf_addr,
    output logic [7:0]  buf_data,
    output logic        buf_we,
    output logic        busy,
    output logic        overrun
);

    localparam int COL_W = $clog2(COLUMNS);
    localparam int ROW_W = $clog2(ROWS + 1);
    localparam int LL_W  = $clog2(ROWS * GLYPH_H + 1);

    state_t            state, state_nxt;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [2:0]        glyph_line;
    logic              half;
    logic              scale_q;
    logic [LL_W-1:0]   lines_left;
    logic [1:0]        pace;
    logic [7:0]        char_q;
    logic              overrun_q;

    logic              pix;
    logic [K_W-1:0]    k;
    logic              k_last;
    logic              sh_load;
    logic              sh_shift;

    logic              idle;
    logic              aborting;
    logic              pace_tick;
    logic              pace_wrap;
    logic              trig;
    logic              start_line;
    logic              char_last;
    logic              char_done;

    assign idle      = (state == IDLE);
    assign aborting  = frame_start || mode_changed;
    // Scanlines only pace rendering while lines remain in the frame.
    assign pace_tick = scanline_start && (lines_left != '0);
    assign pace_wrap = pace_tick && (pace == (scale_q ? 2'd3 : 2'd1));
    assign trig      = render_start || pace_wrap;
    assign start_line = trig && idle && !aborting;
    assign char_last = (col == COL_W'(COLUMNS - 1));
    assign char_done = (state == PIXELS) && k_last;

    chroni_glyph_shifter u_shifter (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .load    (sh_load),
        .shift   (sh_shift),
        .glyph   (font_data),
        .pix     (pix),
        .k       (k),
        .last    (k_last)
    );

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        text_addr = '0;
        font_addr = '0;
        buf_addr  = '0;
        buf_data  = PIX_BG;
        buf_we    = 1'b0;
        read_text = 1'b0;
        read_font = 1'b0;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;

        case (state)
            IDLE: begin
                if (trig) state_nxt = TEXT_RD;
            end
            TEXT_RD: begin
                read_text = 1'b1;
                text_addr = text_base + 16'(row) * 16'(COLUMNS) + 16'(col);
                state_nxt = TEXT_WAIT;
            end
            TEXT_WAIT: begin
                state_nxt = FONT_RD;
            end
            FONT_RD: begin
                read_font = 1'b1;
                font_addr = {char_q, glyph_line};
                state_nxt = FONT_WAIT;
            end
            FONT_WAIT: begin
                sh_load   = 1'b1;
                state_nxt = PIXELS;
            end
            PIXELS: begin
                buf_we    = 1'b1;
                sh_shift  = 1'b1;
                // col*8 + k is just the concatenation {col, k}.
                buf_addr  = (half ? 11'(HALF_OFFSET) : 11'd0) + 11'({col, k});
                buf_data  = pix ? PIX_FG : PIX_BG;
                if (k_last) state_nxt = char_last ? IDLE : TEXT_RD;
            end
            default: state_nxt = IDLE;
        endcase

        if (aborting) state_nxt = IDLE;
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            col        <= '0;
            row        <= '0;
            glyph_line <= '0;
            half       <= 1'b0;
            scale_q    <= 1'b0;
            lines_left <= '0;
            pace       <= '0;
            char_q     <= '0;
        end else if (frame_start) begin
            col        <= '0;
            row        <= '0;
            glyph_line <= '0;
            half       <= 1'b0;
            lines_left <= '0;
            pace       <= '0;
        end else if (mode_changed) begin
            col        <= '0;
            lines_left <= '0;
        end else begin
            // render_start only rewinds the frame when it is actually accepted.
            if (render_start && idle) begin
                row        <= '0;
                glyph_line <= '0;
                half       <= 1'b0;
                lines_left <= LL_W'(ROWS * GLYPH_H);
                pace       <= '0;
            end else if (pace_tick) begin
                pace <= pace_wrap ? 2'd0 : pace + 2'd1;
            end

            if (start_line) begin
                col     <= '0;
                scale_q <= pixel_scale;
            end

            if (state == TEXT_WAIT) char_q <= text_data;

            if (char_done) begin
                if (!char_last) begin
                    col <= col + COL_W'(1);
                end else begin
                    col        <= '0;
                    half       <= ~half;
                    glyph_line <= glyph_line + 3'd1;
                    if (glyph_line == 3'd7) row <= row + ROW_W'(1);
                    lines_left <= lines_left - LL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_q <= 1'b0;
        end else if (trig && !idle && !aborting) begin
            overrun_q <= 1'b1;
        end
    end

    assign busy    = !idle;
    assign overrun = overrun_q;

endmodule
